// File: rtl/neg_serial.sv
// neg_serial: bit-serial sign application.
// Takes an unsigned WIDTH-bit magnitude and a sign flag. Produces the
// WIDTH+1-bit two's-complement value (+in or -in), one magnitude bit per clock,
// LSB first. Negation uses the copy-until-first-one-then-invert rule, so no
// adder is needed. The result register only changes on completion, so it never
// shows partial data.
module neg_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             minus,
  input  logic [WIDTH-1:0] in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   out
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;      // magnitude bits still to be processed
  logic [WIDTH-1:0] res_q, res_d;    // result bits collected so far, filled from the top
  logic [CNT_W-1:0] cnt_q, cnt_d;    // bits processed in this conversion
  logic             seen_q, seen_d;  // a 1 bit has already been processed
  logic             sign_q, sign_d;  // captured minus flag
  logic [WIDTH:0]   out_q, out_d;    // completed result, held between conversions

  logic             load;
  logic             bit_res;
  logic             seen_nxt;
  logic [WIDTH-1:0] res_shift;

  // Result bit for one magnitude bit: below and at the first 1 the bit is
  // copied; above it the bit is inverted, but only when negating.
  function automatic logic neg_bit(input logic sign, input logic seen, input logic b);
    return b ^ (sign & seen);
  endfunction

  // Per-bit datapath terms for the bit currently at the bottom of the shift register.
  always_comb begin
    bit_res   = neg_bit(sign_q, seen_q, sr_q[0]);
    seen_nxt  = seen_q | sr_q[0];
    res_shift = {bit_res, res_q[WIDTH-1:1]};
  end

  // A new operand is taken in IDLE. It is also taken in the DONE cycle, so that
  // a continuously held start restarts every WIDTH+1 clocks. The DONE cycle is
  // the earliest point where the previous result is complete.
  assign load = start && ((state_q == IDLE) || (state_q == DONE));

  // Next-state and datapath update; everything holds by default.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    seen_d  = seen_q;
    sign_d  = sign_q;
    out_d   = out_q;

    case (state_q)
      IDLE: begin
        if (load) begin
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        sr_d   = sr_q >> 1;
        res_d  = res_shift;
        seen_d = seen_nxt;
        cnt_d  = cnt_q + CNT_ONE;
        if (cnt_q == LAST_BIT) begin
          // The MSB is the sign, except for a zero magnitude: -0 is +0.
          out_d   = {sign_q & seen_nxt, res_shift};
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = load ? SHIFT : IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (load) begin
      sr_d   = in;
      sign_d = minus;
      res_d  = '0;
      cnt_d  = '0;
      seen_d = 1'b0;
    end
  end

  // State and datapath registers; reset takes priority over every transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      seen_q  <= 1'b0;
      sign_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      sign_q  <= sign_d;
      out_q   <= out_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign out  = out_q;

endmodule

// File: tb/tb_neg_serial.sv
// Testbench for neg_serial at WIDTH=4: directed vectors, back-to-back run,
// mid-conversion reset and an exhaustive sweep of all sign/magnitude pairs.
module tb_neg_serial;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             start;
  logic             minus;
  logic [WIDTH-1:0] in;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   out;

  int n_checks;
  int n_errors;

  neg_serial #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .minus (minus),
    .in    (in),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge. Launches one conversion, walks its whole timeline
  // and returns at the falling edge after the DONE cycle. With scramble set,
  // in/minus change on every SHIFT cycle.
  task automatic run_conv(input string tag, input logic m, input logic [WIDTH-1:0] v,
                          input logic [WIDTH:0] exp, input bit scramble);
    start = 1'b1;
    minus = m;
    in    = v;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      check({tag, " busy"}, busy, 1'b1);
      check({tag, " done-low"}, done, 1'b0);
      if (scramble) begin
        minus = ~m;
        in    = v ^ WIDTH'(k + 5);
      end
      @(negedge clk);
    end
    check({tag, " done"}, done, 1'b1);
    check({tag, " busy-off"}, busy, 1'b0);
    check({tag, " out"}, out, exp);
    @(negedge clk);
    check({tag, " done-pulse"}, done, 1'b0);
    check({tag, " out-held"}, out, exp);
  endtask

  logic [WIDTH:0]   ref_val;
  logic [WIDTH-1:0] b2b_in [3];
  logic             b2b_m  [3];
  logic [WIDTH:0]   b2b_exp[3];

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst   = 1'b1;
    start = 1'b1;
    minus = 1'b1;
    in    = 4'b0101;

    // Reset held with start high: nothing may begin.
    repeat (2) @(negedge clk);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst out", out, 5'b00000);

    // First edge with rst low accepts the start: -5.
    rst = 1'b0;
    run_conv("neg5", 1'b1, 4'b0101, 5'b11011, 1'b0);

    run_conv("neg0", 1'b1, 4'b0000, 5'b00000, 1'b0);
    run_conv("neg8", 1'b1, 4'b1000, 5'b11000, 1'b0);
    run_conv("neg15", 1'b1, 4'b1111, 5'b10001, 1'b0);
    run_conv("pos10-scr", 1'b0, 4'b1010, 5'b01010, 1'b1);
    run_conv("neg3-scr", 1'b1, 4'b0011, 5'b11101, 1'b1);

    // Idle gap: out must stay put while no conversion runs.
    repeat (3) @(negedge clk);
    check("idle out", out, 5'b11101);
    check("idle busy", busy, 1'b0);

    // Start held high: conversions every WIDTH+1 cycles; operand for the next one
    // is presented in the DONE cycle, garbage otherwise.
    b2b_m[0] = 1'b1; b2b_in[0] = 4'b0110; b2b_exp[0] = 5'b11010;
    b2b_m[1] = 1'b0; b2b_in[1] = 4'b1001; b2b_exp[1] = 5'b01001;
    b2b_m[2] = 1'b1; b2b_in[2] = 4'b0001; b2b_exp[2] = 5'b11111;
    start = 1'b1;
    minus = b2b_m[0];
    in    = b2b_in[0];
    for (int k = 0; k < 3 * (WIDTH + 1); k++) begin
      @(negedge clk);
      if ((k % (WIDTH + 1)) == WIDTH) begin
        check("b2b done", done, 1'b1);
        check("b2b busy-off", busy, 1'b0);
        check("b2b out", out, b2b_exp[k / (WIDTH + 1)]);
        if (k / (WIDTH + 1) < 2) begin
          minus = b2b_m[k / (WIDTH + 1) + 1];
          in    = b2b_in[k / (WIDTH + 1) + 1];
        end else begin
          start = 1'b0;
        end
      end else begin
        check("b2b busy", busy, 1'b1);
        check("b2b done-low", done, 1'b0);
        minus = ~minus;
        in    = in + 4'd3;
      end
    end
    @(negedge clk);
    check("b2b end busy", busy, 1'b0);
    check("b2b end done", done, 1'b0);
    check("b2b end out", out, 5'b11111);

    // Reset two cycles into SHIFT: result is discarded, out cleared, no done.
    start = 1'b1;
    minus = 1'b1;
    in    = 4'b0111;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst busy", busy, 1'b0);
    check("midrst done", done, 1'b0);
    check("midrst out", out, 5'b00000);
    for (int k = 0; k < WIDTH + 2; k++) begin
      @(negedge clk);
      check("midrst no-done", done, 1'b0);
      check("midrst out-zero", out, 5'b00000);
    end
    run_conv("post-rst neg7", 1'b1, 4'b0111, 5'b11001, 1'b0);

    // Exhaustive sweep against an arithmetic reference.
    for (int s = 0; s < 32; s++) begin
      logic             m;
      logic [WIDTH-1:0] v;
      m = s[4];
      v = s[3:0];
      ref_val = m ? (5'd0 - {1'b0, v}) : {1'b0, v};
      run_conv($sformatf("sweep m=%0d in=%0d", m, v), m, v, ref_val, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
